bcd_scan_mux: RTL and testbench



---
 rtl/bcd_scan_if.sv | 15 +
 rtl/bcd_scan_mux.sv | 166 ++++++++++++++++
 tb/tb_bcd_scan_mux.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_if.sv
// Input handshake bundle for bcd_scan_mux.
//   bcd_in   : packed BCD word, nibble k = bcd_in[4k+3:4k], digit 0 least significant
//   in_valid : bcd_in is valid (source side)
//   in_ready : sink can accept a word this cycle
// master = word source, slave = bcd_scan_mux.
interface bcd_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                in_valid;
  logic                in_ready;

  modport master (output bcd_in, output in_valid, input in_ready);
  modport slave  (input bcd_in, input in_valid, output in_ready);
endinterface

// File: rtl/bcd_scan_mux.sv
// Multi-digit BCD display scanner: double-buffers a packed BCD word taken
// through a valid/ready handshake and time-multiplexes one nibble per slot onto
// a shared 7-segment decoder, with active-low digit enables and a dark gap at
// the start of every slot to avoid ghosting.
// Optional: define LEADING_ZERO_BLANK_EN to keep leading zero digits (k > 0) dark.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_if        : bcd_scan_if.slave (bcd_in / in_valid / in_ready)
//   bcd_out      : nibble to the decoder, always 0..9
//   an_n         : active-low digit enables, at most one low
//   frame_start  : one-cycle pulse on the frame transfer cycle
//   bcd_err      : sticky, active word holds a non-BCD nibble
module bcd_scan_mux #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_scan_if.slave         in_if,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_start,
  output logic              bcd_err
);

  localparam int unsigned WW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] SLOT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t        state, state_d;
  logic [CW-1:0] slot_cnt, slot_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [WW-1:0] active, active_nxt, pending;
  logic          pend_valid, pend_valid_nxt;
  logic          in_ready;
  logic          slot_wrap_c, xfer_c, accept_c, load_c;
  logic [3:0]    nib_c;
  logic          lz_hit_c;
  logic [DIGITS-1:0] lz_dark_c;

  logic [DIGITS-1:0] an_n_d;
  logic [3:0]        bcd_out_d;
  logic              frame_start_d, bcd_err_d, in_ready_d;

  assign in_if.in_ready = in_ready;

  // Next counter / buffer values; registered outputs are derived from these so
  // they line up with the counter value of the cycle they appear in.
  always_comb begin
    slot_wrap_c    = (slot_cnt == SLOT_LAST);
    xfer_c         = slot_wrap_c && (idx == IDX_LAST);
    accept_c       = in_if.in_valid && in_ready;
    load_c         = xfer_c && pend_valid;
    slot_nxt       = slot_wrap_c ? '0 : slot_cnt + CW'(1);
    idx_nxt        = idx;
    if (slot_wrap_c) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    active_nxt     = load_c ? pending : active;
    pend_valid_nxt = pend_valid;
    if (accept_c)    pend_valid_nxt = 1'b1;
    else if (load_c) pend_valid_nxt = 1'b0;
  end

  // Counters and word buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
    end else begin
      slot_cnt   <= slot_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      pend_valid <= pend_valid_nxt;
      if (accept_c) pending <= in_if.bcd_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BLANK;
    else        state <= state_d;
  end

  // FSM next state: dark until slot_cnt reaches BLANK_CYC, lit until the wrap.
  always_comb begin
    state_d = state;
    case (state)
      ST_BLANK: if (slot_nxt == SLOT_SHOW) state_d = ST_SHOW;
      ST_SHOW:  if (slot_wrap_c)           state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zrun;
  // Digit k > 0 is dark when it and every higher nibble are zero.
  always_comb begin
    zrun      = 1'b1;
    lz_dark_c = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zrun         = zrun && (active_nxt[4*k +: 4] == 4'd0);
      lz_dark_c[k] = zrun;
    end
  end
`else
  assign lz_dark_c = '0;
`endif

  // Select the nibble of the digit about to be driven.
  always_comb begin
    nib_c    = 4'd0;
    lz_hit_c = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib_c    = active_nxt[4*k +: 4];
        lz_hit_c = lz_dark_c[k];
      end
    end
  end

  // FSM outputs (next values of the output registers).
  always_comb begin
    an_n_d        = '1;
    bcd_out_d     = bcd_out;
    bcd_err_d     = bcd_err;
    frame_start_d = (slot_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);
    in_ready_d    = ~pend_valid_nxt;
    if (load_c) bcd_err_d = 1'b0;
    if (state_d == ST_SHOW) begin
      if (nib_c > 4'd9) begin
        // Non-BCD nibble: keep the digit dark and never pass it to the decoder.
        bcd_err_d = 1'b1;
        bcd_out_d = 4'd0;
      end else if (!lz_hit_c) begin
        an_n_d[idx_nxt] = 1'b0;
        bcd_out_d       = nib_c;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n        <= '1;
      bcd_out     <= 4'd0;
      frame_start <= 1'b0;
      bcd_err     <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      an_n        <= an_n_d;
      bcd_out     <= bcd_out_d;
      frame_start <= frame_start_d;
      bcd_err     <= bcd_err_d;
      in_ready    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux with DIGITS=4, PRESCALE=8, BLANK_CYC=2.
// Cycle n = n rising edges after reset release; inputs driven and outputs
// sampled on the falling edge.
module tb_bcd_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd_out;
  logic [3:0] an_n;
  logic       frame_start;
  logic       bcd_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bcd_scan_if #(.DIGITS(4)) bus ();

  bcd_scan_mux #(.DIGITS(4), .PRESCALE(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (bus),
    .bcd_out     (bcd_out),
    .an_n        (an_n),
    .frame_start (frame_start),
    .bcd_err     (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.bcd_in   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Present a word for exactly one cycle starting at the current cycle.
  task automatic send(input logic [15:0] w);
    bus.bcd_in   = w;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.bcd_in   = '0;

    // 1: reset values and idle scan of an all-zero word
    repeat (2) @(negedge clk);
    check_eq("rst_an_n", 32'(an_n), 32'hF);
    check_eq("rst_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check_eq("rst_frame_start", 32'(frame_start), 32'h0);
    check_eq("rst_bcd_err", 32'(bcd_err), 32'h0);
    do_reset();
    check_eq("t1_c0_an_n", 32'(an_n), 32'hF);
    goto(1);  check_eq("t1_c1_an_n", 32'(an_n), 32'hF);
    goto(2);  check_eq("t1_c2_an_n", 32'(an_n), 32'hE);
              check_eq("t1_c2_bcd_out", 32'(bcd_out), 32'h0);
    goto(7);  check_eq("t1_c7_an_n", 32'(an_n), 32'hE);
    goto(8);  check_eq("t1_c8_an_n", 32'(an_n), 32'hF);
    goto(10); check_eq("t1_c10_an_n", 32'(an_n), 32'hD);
    goto(30); check_eq("t1_c30_frame", 32'(frame_start), 32'h0);
    goto(31); check_eq("t1_c31_frame", 32'(frame_start), 32'h1);
              check_eq("t1_in_ready", 32'(bus.in_ready), 32'h1);
              check_eq("t1_bcd_err", 32'(bcd_err), 32'h0);
    goto(32); check_eq("t1_c32_frame", 32'(frame_start), 32'h0);
    goto(63); check_eq("t1_c63_frame", 32'(frame_start), 32'h1);

    // 2: accept 1234 at cycle 5, displayed from the frame at cycle 32
    do_reset();
    goto(5);  send(16'h1234);
    check_eq("t2_ready_drop", 32'(bus.in_ready), 32'h0);
    goto(26); check_eq("t2_old_word", 32'(bcd_out), 32'h0);
              check_eq("t2_old_an_n", 32'(an_n), 32'h7);
    goto(32); check_eq("t2_ready_back", 32'(bus.in_ready), 32'h1);
    goto(34); check_eq("t2_d0_an_n", 32'(an_n), 32'hE);
              check_eq("t2_d0_val", 32'(bcd_out), 32'h4);
    goto(39); check_eq("t2_d0_end", 32'(bcd_out), 32'h4);
    goto(42); check_eq("t2_d1_an_n", 32'(an_n), 32'hD);
              check_eq("t2_d1_val", 32'(bcd_out), 32'h3);
    goto(50); check_eq("t2_d2_an_n", 32'(an_n), 32'hB);
              check_eq("t2_d2_val", 32'(bcd_out), 32'h2);
    goto(58); check_eq("t2_d3_an_n", 32'(an_n), 32'h7);
              check_eq("t2_d3_val", 32'(bcd_out), 32'h1);

    // 3: back-to-back words with in_valid held high
    do_reset();
    goto(3);
    bus.bcd_in   = 16'h1111;
    bus.in_valid = 1'b1;
    step();
    check_eq("t3_first_acc", 32'(bus.in_ready), 32'h0);
    bus.bcd_in = 16'h2222;
    goto(31); check_eq("t3_c31_ready", 32'(bus.in_ready), 32'h0);
    goto(32); check_eq("t3_c32_ready", 32'(bus.in_ready), 32'h1);
    step();   check_eq("t3_second_acc", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b0;
    goto(34); check_eq("t3_frame1_val", 32'(bcd_out), 32'h1);
    goto(66); check_eq("t3_frame2_val", 32'(bcd_out), 32'h2);
              check_eq("t3_frame2_an_n", 32'(an_n), 32'hE);

    // 4: non-BCD nibble in digit 1, then cleared by a good word
    do_reset();
    send(16'h12A4);
    goto(34); check_eq("t4_d0_val", 32'(bcd_out), 32'h4);
              check_eq("t4_d0_err", 32'(bcd_err), 32'h0);
    goto(42); check_eq("t4_d1_an_n", 32'(an_n), 32'hF);
              check_eq("t4_d1_val", 32'(bcd_out), 32'h0);
              check_eq("t4_d1_err", 32'(bcd_err), 32'h1);
    goto(50); check_eq("t4_d2_an_n", 32'(an_n), 32'hB);
              check_eq("t4_d2_val", 32'(bcd_out), 32'h2);
    send(16'h0005);
    goto(58); check_eq("t4_d3_val", 32'(bcd_out), 32'h1);
    goto(63); check_eq("t4_err_held", 32'(bcd_err), 32'h1);
    goto(64); check_eq("t4_err_clr", 32'(bcd_err), 32'h0);
    goto(66); check_eq("t4_new_val", 32'(bcd_out), 32'h5);
              check_eq("t4_new_an_n", 32'(an_n), 32'hE);
`ifdef LEADING_ZERO_BLANK_EN
    goto(74); check_eq("t4_d1_lz_an_n", 32'(an_n), 32'hF);
`else
    goto(74); check_eq("t4_d1_an_n2", 32'(an_n), 32'hD);
              check_eq("t4_d1_val2", 32'(bcd_out), 32'h0);
`endif

    // 5: reset during the digit 2 window drops outputs and the pending word
    do_reset();
    send(16'h5678);
    goto(34); check_eq("t5_d0_val", 32'(bcd_out), 32'h8);
    goto(44); send(16'h9999);
    goto(52); check_eq("t5_pre_an_n", 32'(an_n), 32'hB);
              check_eq("t5_pre_val", 32'(bcd_out), 32'h6);
              check_eq("t5_pre_ready", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_an_n", 32'(an_n), 32'hF);
    check_eq("t5_rst_ready", 32'(bus.in_ready), 32'h1);
    check_eq("t5_rst_val", 32'(bcd_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    goto(2);  check_eq("t5_post_an_n", 32'(an_n), 32'hE);
              check_eq("t5_post_val", 32'(bcd_out), 32'h0);
    goto(34); check_eq("t5_no_pend_val", 32'(bcd_out), 32'h0);
              check_eq("t5_no_pend_an_n", 32'(an_n), 32'hE);

    // 6: leading zeros
    do_reset();
    send(16'h0050);
    goto(34); check_eq("t6_d0_an_n", 32'(an_n), 32'hE);
              check_eq("t6_d0_val", 32'(bcd_out), 32'h0);
    goto(42); check_eq("t6_d1_an_n", 32'(an_n), 32'hD);
              check_eq("t6_d1_val", 32'(bcd_out), 32'h5);
`ifdef LEADING_ZERO_BLANK_EN
    goto(50); check_eq("t6_d2_dark", 32'(an_n), 32'hF);
    goto(58); check_eq("t6_d3_dark", 32'(an_n), 32'hF);
`else
    goto(50); check_eq("t6_d2_an_n", 32'(an_n), 32'hB);
              check_eq("t6_d2_val", 32'(bcd_out), 32'h0);
    goto(58); check_eq("t6_d3_an_n", 32'(an_n), 32'h7);
              check_eq("t6_d3_val", 32'(bcd_out), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
